ysyx_23060061_mdu: RTL and testbench

YSYX_23060061_MDU -- requirements
Module: ysyx_23060061_mdu

---
 rtl/ysyx_23060061_mdu.sv | 157 +++++++++++++++
 tb/tb_ysyx_23060061_mdu.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_mdu.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring divide on operand magnitudes, with the sign fixup applied on the last step.
module ysyx_23060061_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       mdOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] mdOut,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_mb;
    logic [WIDTH-1:0] r_hi;     // product high half, or partial remainder
    logic [WIDTH-1:0] r_lo;     // multiplier bits, or dividend shifting into quotient
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_special;
    logic [WIDTH-1:0] r_result;

    logic             w_accept;
    logic             w_a_sgn;
    logic             w_b_sgn;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_ma;
    logic [WIDTH-1:0] w_mb;
    logic             w_div0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_spec_res;

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign mdOut     = (r_state == S_DONE) ? r_result : '0;

    assign w_accept = in_valid & in_ready;
    assign w_a_sgn  = (mdOp == 3'b001) | (mdOp == 3'b010) | (mdOp == 3'b100) | (mdOp == 3'b110);
    assign w_b_sgn  = (mdOp == 3'b001) | (mdOp == 3'b100) | (mdOp == 3'b110);
    assign w_a_neg  = w_a_sgn & a[WIDTH-1];
    assign w_b_neg  = w_b_sgn & b[WIDTH-1];
    assign w_ma     = w_a_neg ? (~a + 1'b1) : a;
    assign w_mb     = w_b_neg ? (~b + 1'b1) : b;

    // Division corner cases resolve at accept and bypass the iteration.
    assign w_div0 = mdOp[2] & (b == '0);
    assign w_ovf  = mdOp[2] & ~mdOp[0] & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);
    always_comb begin
        // NOTE: default first so every path assigns the output and no latch is inferred.
        w_spec_res = '0;
        if (w_div0)
            w_spec_res = mdOp[1] ? a : '1;
        else if (w_ovf)
            w_spec_res = mdOp[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [WIDTH-1:0]   w_hi_n;
    logic [WIDTH-1:0]   w_lo_n;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_calc_res;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mb} : '0);
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_mb});
    // Modular subtract is exact whenever it is used, since the remainder stays below r_mb.
    assign w_sub   = w_shift[WIDTH-1:0] - r_mb;
    assign w_hi_n  = r_op[2] ? (w_ge ? w_sub : w_shift[WIDTH-1:0]) : w_sum[WIDTH:1];
    assign w_lo_n  = r_op[2] ? {r_lo[WIDTH-2:0], w_ge} : {w_sum[0], r_lo[WIDTH-1:1]};

    assign w_prod = r_neg_q ? (~{w_hi_n, w_lo_n} + 1'b1) : {w_hi_n, w_lo_n};
    assign w_quo  = r_neg_q ? (~w_lo_n + 1'b1) : w_lo_n;
    assign w_rem  = r_neg_r ? (~w_hi_n + 1'b1) : w_hi_n;

    always_comb begin
        case (r_op)
            3'b000:                 w_calc_res = w_prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: w_calc_res = w_prod[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         w_calc_res = w_quo;
            default:                w_calc_res = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_mb      <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_special <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_CALC;
                        r_cnt     <= '0;
                        r_op      <= mdOp;
                        r_mb      <= w_mb;
                        r_hi      <= '0;
                        r_lo      <= w_ma;
                        r_neg_q   <= w_a_neg ^ w_b_neg;
                        r_neg_r   <= w_a_neg;
                        r_special <= w_div0 | w_ovf;
                        r_result  <= w_spec_res;
                    end
                end
                S_CALC: begin
                    if (kill) begin
                        r_state <= S_IDLE;
                    end else if (r_special) begin
                        r_state <= S_DONE;
                    end else begin
                        r_hi  <= w_hi_n;
                        r_lo  <= w_lo_n;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(WIDTH - 1)) begin
                            r_state  <= S_DONE;
                            r_result <= w_calc_res;
                        end
                    end
                end
                S_DONE: begin
                    if (kill || out_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060061_mdu.sv
// Self-checking bench for ysyx_23060061_mdu: directed corner cases plus randomized
// operations compared against a plain-arithmetic RV32M reference.
module tb_ysyx_23060061_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  mdOp;
    logic [31:0] a;
    logic [31:0] b;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] mdOut;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_23060061_mdu #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mdOp      (mdOp),
        .a         (a),
        .b         (b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mdOut     (mdOut),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // RV32M semantics straight from the ISA definition, using 64-bit integer arithmetic.
    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      ux;
        logic [63:0] p;
        logic        ovf;
        sx  = $signed(x);
        sy  = $signed(y);
        ux  = {32'd0, x};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * {32'd0, y}; return p[63:32]; end
            3'd3: begin p = ux * {32'd0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sx / sy;
                return p[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'd0;
                p = sx % sy;
                return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        if (op[2] && (y == 0)) return 2;
        if (op[2] && !op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 2;
        return 33;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, measure accept-to-out_valid latency, check the result, then handshake.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input bit kill_at_accept);
        logic [31:0] exp;
        int          lat;
        exp = ref_mdu(op, x, y);
        @(negedge clk);
        check({tag, "_in_ready"}, in_ready, 1);
        in_valid = 1'b1;
        mdOp     = op;
        a        = x;
        b        = y;
        kill     = kill_at_accept;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        a        = $urandom;
        b        = $urandom;
        mdOp     = 3'($urandom);
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, exp_latency(op, x, y));
        check({tag, "_result"}, mdOut, exp);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_after"}, {in_ready, out_valid, busy}, 3'b100);
        check({tag, "_idle_mdout"}, mdOut, 0);
    endtask

    initial begin
        logic [31:0] held;
        int          seen_valid;
        logic [2:0]  rop;
        logic [31:0] rx;
        logic [31:0] ry;

        rst       = 1'b1;
        in_valid  = 1'b0;
        mdOp      = '0;
        a         = '0;
        b         = '0;
        kill      = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_mdout", mdOut, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("mul_7_m3", 3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op("mulh_7_m3", 3'b001, 32'd7, 32'hFFFF_FFFD, 1'b0);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2, 1'b0);
        run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 1'b0);
        run_op("remu_100_7", 3'b111, 32'd100, 32'd7, 1'b0);
        run_op("divu_by0", 3'b101, 32'd5, 32'd0, 1'b0);
        run_op("rem_by0", 3'b110, 32'd5, 32'd0, 1'b0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("kill_in_idle", 3'b001, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

        // Consumer stalls for 10 cycles: result and handshake state must hold.
        @(negedge clk);
        in_valid = 1'b1; mdOp = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (32) @(posedge clk);
        #1;
        check("stall_first_valid", out_valid, 1);
        held = ref_mdu(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", out_valid, 1);
            check("stall_mdout", mdOut, held);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall_release", {in_ready, out_valid}, 2'b10);

        // Kill on CALC cycle 12 aborts the op with no result ever presented.
        @(negedge clk);
        in_valid = 1'b1; mdOp = 3'b000; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        check("kill_busy_before", busy, 1);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_idle", {in_ready, out_valid, busy}, 3'b100);
        seen_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid++;
        end
        check("kill_no_valid", seen_valid, 0);

        // Reset mid-CALC, with a competing kill, returns everything to reset values.
        @(negedge clk);
        in_valid = 1'b1; mdOp = 3'b100; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1; kill = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; kill = 1'b0;
        check("rst_mid_outputs", {in_ready, out_valid, busy}, 3'b100);
        check("rst_mid_mdout", mdOut, 0);
        run_op("after_rst_div", 3'b100, 32'd1000, 32'hFFFF_FFFD, 1'b0);

        for (int i = 0; i < 200; i++) begin
            rop = 3'($urandom_range(0, 7));
            rx  = pick_operand();
            ry  = pick_operand();
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, rx, ry, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
